sys_regfile_cmd_ctrl: RTL and testbench
=======================================

Name: sys_regfile_cmd_ctrl

Overview:
Command controller that sits directly upstream of the system register file. It parses byte frames from the UART receive path and turns them into register-file write and read strobes. Read results come back from the register file and are forwarded to the UART transmit path. Frame errors are reported through a one-cycle status pulse.

Parameters:
WIDTH, 8, data width of the register file and of the UART bytes.
DEPTH, 16, number of register-file entries; ADDR_W = $clog2(DEPTH).
GAP_TIMEOUT, 255, maximum idle cycles allowed between bytes of one frame.
RD_TIMEOUT, 4, maximum cycles to wait for RF_RdData_Valid after RF_RdEn.
ERR_CODE, 8'hEE, byte transmitted when a read fails.

Ports:
CLK  in  1  system clock; all logic is on the rising edge.
RST  in  1  reset; synchronous and active-high.
RX_P_DATA  in  WIDTH  received byte.
RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid in that cycle.
RF_WrEn  out  1  register-file write strobe.
RF_RdEn  out  1  register-file read strobe.
RF_Address  out  ADDR_W  register-file address.
RF_WrData  out  WIDTH  register-file write data.
RF_RdData  in  WIDTH  register-file read data.
RF_RdData_Valid  in  1  register-file read-valid flag; may stay high after a read.
TX_P_DATA  out  WIDTH  byte to transmit.
TX_D_VLD  out  1  transmit request.
TX_READY  in  1  transmitter accepts the byte.
CMD_ERR  out  1  one-cycle pulse on any dropped or failed frame.
BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - State goes to IDLE.
  - All outputs go to 0: RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_DATA, TX_D_VLD, CMD_ERR, BUSY.
  - The gap and read-timeout counters clear.
  - Reset overrides any frame in progress; a partial frame is discarded and no strobe is emitted.
- Frame formats:
  - Write: 8'hAA, ADDR, DATA.
  - Read: 8'hBB, ADDR.
  - Bytes are taken only in cycles where RX_D_VLD=1.
- State machine: IDLE, WR_ADDR, WR_DATA, WR_ISSUE, RD_ADDR, RD_ISSUE, RD_WAIT, TX_SEND.
- IDLE:
  - 8'hAA goes to WR_ADDR; 8'hBB goes to RD_ADDR.
  - Any other byte is ignored silently: no CMD_ERR, stay in IDLE.
- WR_ADDR / RD_ADDR:
  - The received byte is latched as the address.
  - If the byte is >= DEPTH, CMD_ERR pulses and the state returns to IDLE.
    - For a read, ERR_CODE is also sent: go to TX_SEND with TX_P_DATA=ERR_CODE.
  - Otherwise go to WR_DATA or RD_ISSUE respectively.
- WR_DATA: the byte is latched into RF_WrData; go to WR_ISSUE.
- WR_ISSUE: RF_WrEn=1 for exactly one cycle with RF_Address and RF_WrData stable; then IDLE. This is 1 cycle after the DATA byte strobe.
- RD_ISSUE: RF_RdEn=1 for exactly one cycle; then RD_WAIT.
- RD_WAIT:
  - A stale RF_RdData_Valid left over from an earlier read is harmless. The register file updates data on the RF_RdEn edge, so the first RD_WAIT cycle already sees fresh data.
  - The first cycle with RF_RdData_Valid=1 latches RF_RdData into TX_P_DATA and goes to TX_SEND.
  - If RD_TIMEOUT cycles pass without valid, TX_P_DATA=ERR_CODE, CMD_ERR pulses, and the state goes to TX_SEND.
- TX_SEND:
  - TX_D_VLD=1 with TX_P_DATA held stable until a cycle where TX_READY=1.
  - After that cycle, TX_D_VLD=0 and the state goes to IDLE.
  - There is no timeout on TX_READY.
- Gap timeout:
  - Applies in WR_ADDR, WR_DATA and RD_ADDR.
  - The counter increments every cycle without RX_D_VLD and clears on each byte.
  - When the counter reaches GAP_TIMEOUT, CMD_ERR pulses and the state returns to IDLE with no strobes.
- RX bytes arriving in WR_ISSUE, RD_ISSUE, RD_WAIT or TX_SEND are dropped and CMD_ERR pulses once per dropped byte. The controller does not buffer.
- RF_WrEn and RF_RdEn are never high in the same cycle.
- Write protection of low addresses is the register file's concern. This block issues the strobe for any address < DEPTH.
- Latency from the last RX byte strobe:
  - Write: RF_WrEn is high in cycle +1.
  - Read: RF_RdEn is high in cycle +1; TX_D_VLD is high no earlier than cycle +3.

Test Plan:
- Write then read back:
  - Send AA,07,46; expect one RF_WrEn pulse with Address=7, WrData=8'h46.
  - Then send BB,07 with the register file model returning 46; expect TX_D_VLD with TX_P_DATA=8'h46, held until TX_READY is asserted 5 cycles later.
- Out-of-range address:
  - Send AA,10 with DEPTH=16; expect CMD_ERR pulse, no RF_WrEn, back in IDLE.
  - Send BB,12; expect TX_P_DATA=8'hEE.
- Gap timeout: send AA,05, then idle for GAP_TIMEOUT cycles; expect CMD_ERR, no strobe, BUSY=0. A following AA,05,09 writes normally.
- Read timeout: model holds RF_RdData_Valid=0 after BB,03; expect ERR_CODE transmitted and CMD_ERR after RD_TIMEOUT cycles.
- Junk and overlap:
  - Send 3C in IDLE; expect ignored, no CMD_ERR.
  - Send a byte during TX_SEND with TX_READY=0; expect CMD_ERR and the original TX byte unchanged.
- Reset mid-frame: assert RST after AA,04; expect all outputs 0 next edge, and a subsequent DATA byte does not cause a write.

Source files
------------

// File: rtl/sys_regfile_cmd_ctrl_if.sv
// Bus bundle between the UART/register-file side and the command controller.
// master = the controller, slave = the surrounding UART and register file.
interface sys_regfile_cmd_ctrl_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
);
   logic [WIDTH-1:0]  RX_P_DATA;
   logic              RX_D_VLD;
   logic              RF_WrEn;
   logic              RF_RdEn;
   logic [ADDR_W-1:0] RF_Address;
   logic [WIDTH-1:0]  RF_WrData;
   logic [WIDTH-1:0]  RF_RdData;
   logic              RF_RdData_Valid;
   logic [WIDTH-1:0]  TX_P_DATA;
   logic              TX_D_VLD;
   logic              TX_READY;
   logic              CMD_ERR;
   logic              BUSY;

   modport master (
      input  RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_Valid, TX_READY,
      output RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_DATA, TX_D_VLD,
             CMD_ERR, BUSY
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_Valid, TX_READY,
      input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_DATA, TX_D_VLD,
             CMD_ERR, BUSY
   );
endinterface

// File: rtl/sys_regfile_cmd_ctrl.sv
// Parses AA/ADDR/DATA write and BB/ADDR read frames from the UART receive path
// into register-file strobes, and returns read data (or an error code) to TX.
module sys_regfile_cmd_ctrl #(
   parameter int               WIDTH       = 8,
   parameter int               DEPTH       = 16,
   parameter int               GAP_TIMEOUT = 255,
   parameter int               RD_TIMEOUT  = 4,
   parameter logic [WIDTH-1:0] ERR_CODE    = WIDTH'(8'hEE)
) (
   input logic                  CLK,
   input logic                  RST,
   sys_regfile_cmd_ctrl_if.master bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int GAP_W  = $clog2(GAP_TIMEOUT + 1);
   localparam int RDT_W  = $clog2(RD_TIMEOUT + 1);
   localparam logic [WIDTH-1:0] CMD_WR = WIDTH'(8'hAA);
   localparam logic [WIDTH-1:0] CMD_RD = WIDTH'(8'hBB);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_ADDR,
      S_WR_DATA,
      S_WR_ISSUE,
      S_RD_ADDR,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_TX_SEND
   } state_t;

   state_t            r_state, w_state_next;
   logic [ADDR_W-1:0] r_addr, w_addr_next;
   logic [WIDTH-1:0]  r_wr_data, w_wr_data_next;
   logic [WIDTH-1:0]  r_tx_data, w_tx_data_next;
   logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_next;
   logic [RDT_W-1:0]  r_rd_cnt, w_rd_cnt_next;
   logic              r_cmd_err, w_cmd_err_next;

   logic              w_rx_vld;
   logic [WIDTH-1:0]  w_rx_byte;
   logic              w_addr_ok;
   logic              w_gap_expired;
   logic              w_rd_expired;

   assign w_rx_vld  = bus.RX_D_VLD;
   assign w_rx_byte = bus.RX_P_DATA;
   // One extra bit so the range test stays correct even when DEPTH == 2**WIDTH.
   assign w_addr_ok     = ({1'b0, w_rx_byte} < (WIDTH + 1)'(DEPTH));
   assign w_gap_expired = !w_rx_vld && (r_gap_cnt == GAP_W'(GAP_TIMEOUT - 1));
   assign w_rd_expired  = (r_rd_cnt == RDT_W'(RD_TIMEOUT - 1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_wr_data <= '0;
         r_tx_data <= '0;
         r_gap_cnt <= '0;
         r_rd_cnt  <= '0;
         r_cmd_err <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_addr    <= w_addr_next;
         r_wr_data <= w_wr_data_next;
         r_tx_data <= w_tx_data_next;
         r_gap_cnt <= w_gap_cnt_next;
         r_rd_cnt  <= w_rd_cnt_next;
         r_cmd_err <= w_cmd_err_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_addr_next    = r_addr;
      w_wr_data_next = r_wr_data;
      w_tx_data_next = r_tx_data;
      w_gap_cnt_next = '0;
      w_rd_cnt_next  = '0;
      w_cmd_err_next = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_rx_vld) begin
               if (w_rx_byte == CMD_WR) begin
                  w_state_next = S_WR_ADDR;
               end else if (w_rx_byte == CMD_RD) begin
                  w_state_next = S_RD_ADDR;
               end
            end
         end

         S_WR_ADDR, S_RD_ADDR: begin
            if (w_rx_vld) begin
               w_addr_next = w_rx_byte[ADDR_W-1:0];
               if (!w_addr_ok) begin
                  w_cmd_err_next = 1'b1;
                  // A failed read still answers the host so it is not left waiting.
                  if (r_state == S_RD_ADDR) begin
                     w_tx_data_next = ERR_CODE;
                     w_state_next   = S_TX_SEND;
                  end else begin
                     w_state_next = S_IDLE;
                  end
               end else begin
                  w_state_next = (r_state == S_RD_ADDR) ? S_RD_ISSUE : S_WR_DATA;
               end
            end else if (w_gap_expired) begin
               w_cmd_err_next = 1'b1;
               w_state_next   = S_IDLE;
            end else begin
               w_gap_cnt_next = r_gap_cnt + GAP_W'(1);
            end
         end

         S_WR_DATA: begin
            if (w_rx_vld) begin
               w_wr_data_next = w_rx_byte;
               w_state_next   = S_WR_ISSUE;
            end else if (w_gap_expired) begin
               w_cmd_err_next = 1'b1;
               w_state_next   = S_IDLE;
            end else begin
               w_gap_cnt_next = r_gap_cnt + GAP_W'(1);
            end
         end

         S_WR_ISSUE: begin
            w_cmd_err_next = w_rx_vld;
            w_state_next   = S_IDLE;
         end

         S_RD_ISSUE: begin
            w_cmd_err_next = w_rx_vld;
            w_state_next   = S_RD_WAIT;
         end

         S_RD_WAIT: begin
            w_cmd_err_next = w_rx_vld;
            // The register file refreshes on the RdEn edge, so any valid seen here is current.
            if (bus.RF_RdData_Valid) begin
               w_tx_data_next = bus.RF_RdData;
               w_state_next   = S_TX_SEND;
            end else if (w_rd_expired) begin
               w_tx_data_next = ERR_CODE;
               w_cmd_err_next = 1'b1;
               w_state_next   = S_TX_SEND;
            end else begin
               w_rd_cnt_next = r_rd_cnt + RDT_W'(1);
            end
         end

         S_TX_SEND: begin
            w_cmd_err_next = w_rx_vld;
            if (bus.TX_READY) begin
               w_state_next = S_IDLE;
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign bus.RF_WrEn    = (r_state == S_WR_ISSUE);
   assign bus.RF_RdEn    = (r_state == S_RD_ISSUE);
   assign bus.RF_Address = r_addr;
   assign bus.RF_WrData  = r_wr_data;
   assign bus.TX_P_DATA  = r_tx_data;
   assign bus.TX_D_VLD   = (r_state == S_TX_SEND);
   assign bus.CMD_ERR    = r_cmd_err;
   assign bus.BUSY       = (r_state != S_IDLE);
endmodule

// File: tb/tb_sys_regfile_cmd_ctrl.sv
// Scoreboard bench for sys_regfile_cmd_ctrl with a simple register-file model.
module tb_sys_regfile_cmd_ctrl;
   localparam int         WIDTH       = 8;
   localparam int         DEPTH       = 16;
   localparam int         ADDR_W      = 4;
   localparam int         GAP_TIMEOUT = 255;
   localparam int         RD_TIMEOUT  = 4;
   localparam logic [7:0] ERR_CODE    = 8'hEE;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   logic [7:0] rx_data  = 8'h00;
   logic       rx_vld   = 1'b0;
   logic       tx_ready = 1'b1;
   logic       rf_stall = 1'b0;
   logic [7:0] rf_rd_data;
   logic       rf_rd_vld;
   logic [7:0] rf_mem [DEPTH];

   sys_regfile_cmd_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   assign bus.RX_P_DATA       = rx_data;
   assign bus.RX_D_VLD        = rx_vld;
   assign bus.TX_READY        = tx_ready;
   assign bus.RF_RdData       = rf_rd_data;
   assign bus.RF_RdData_Valid = rf_rd_vld;

   sys_regfile_cmd_ctrl #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .GAP_TIMEOUT(GAP_TIMEOUT),
      .RD_TIMEOUT(RD_TIMEOUT), .ERR_CODE(ERR_CODE)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   int errors     = 0;
   int checks     = 0;
   int err_pulses = 0;
   logic [11:0] exp_wr [$];
   logic [7:0]  exp_tx [$];
   logic [7:0]  shadow [DEPTH];

   // Register-file model: data refreshes on the RdEn edge, valid stays high afterwards.
   always @(posedge CLK) begin
      if (RST) begin
         rf_rd_vld <= 1'b0;
      end else begin
         if (bus.RF_WrEn) rf_mem[bus.RF_Address] <= bus.RF_WrData;
         if (bus.RF_RdEn) begin
            if (rf_stall) begin
               rf_rd_vld <= 1'b0;
            end else begin
               rf_rd_vld  <= 1'b1;
               rf_rd_data <= rf_mem[bus.RF_Address];
            end
         end
      end
   end

   logic       prev_tx_vld   = 1'b0;
   logic       prev_tx_ready = 1'b0;
   logic [7:0] prev_tx_data  = 8'h00;

   always @(negedge CLK) begin
      if (!RST) begin
         if (bus.CMD_ERR === 1'b1) err_pulses++;
         if (bus.RF_WrEn === 1'b1 || bus.RF_RdEn === 1'b1) begin
            checks++;
            if (bus.RF_WrEn === 1'b1 && bus.RF_RdEn === 1'b1) begin
               errors++;
               $display("FAIL strobe_overlap: got WrEn=1 RdEn=1 expected at most one");
            end
         end
         if (bus.RF_WrEn === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got addr=%h data=%h expected no write",
                        bus.RF_Address, bus.RF_WrData);
            end else begin
               logic [11:0] e;
               e = exp_wr.pop_front();
               if ({bus.RF_Address, bus.RF_WrData} !== e) begin
                  errors++;
                  $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                           bus.RF_Address, bus.RF_WrData, e[11:8], e[7:0]);
               end
            end
            $display("write addr=%h data=%h", bus.RF_Address, bus.RF_WrData);
         end
         if (bus.TX_D_VLD === 1'b1 && prev_tx_vld && !prev_tx_ready) begin
            checks++;
            if (bus.TX_P_DATA !== prev_tx_data) begin
               errors++;
               $display("FAIL tx_hold: got %h expected %h", bus.TX_P_DATA, prev_tx_data);
            end
         end
         if (bus.TX_D_VLD === 1'b1 && tx_ready) begin
            checks++;
            if (exp_tx.size() == 0) begin
               errors++;
               $display("FAIL unexpected_tx: got %h expected no byte", bus.TX_P_DATA);
            end else begin
               logic [7:0] t;
               t = exp_tx.pop_front();
               if (bus.TX_P_DATA !== t) begin
                  errors++;
                  $display("FAIL tx_byte: got %h expected %h", bus.TX_P_DATA, t);
               end
            end
            $display("tx byte=%h", bus.TX_P_DATA);
         end
         prev_tx_vld   = (bus.TX_D_VLD === 1'b1);
         prev_tx_ready = tx_ready;
         prev_tx_data  = bus.TX_P_DATA;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_vld  = 1'b1;
      @(posedge CLK);
      #1;
      rx_vld  = 1'b0;
   endtask

   task automatic wait_tx_vld(input int budget, output int n);
      n = 0;
      while (bus.TX_D_VLD !== 1'b1 && n < budget) begin
         @(posedge CLK);
         #1;
         n++;
      end
      checks++;
      if (bus.TX_D_VLD !== 1'b1) begin
         errors++;
         $display("FAIL tx_timeout: got TX_D_VLD=%b after %0d cycles expected 1", bus.TX_D_VLD, n);
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (bus.BUSY !== 1'b0 && n < 40) begin
         idle(1);
         n++;
      end
      idle(2);
      checks++;
      if (bus.BUSY !== 1'b0 || exp_wr.size() != 0 || exp_tx.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got busy=%b wr_left=%0d tx_left=%0d expected 0 0 0",
                  name, bus.BUSY, exp_wr.size(), exp_tx.size());
      end
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if ({bus.RF_WrEn, bus.RF_RdEn, bus.RF_Address, bus.RF_WrData, bus.TX_P_DATA,
           bus.TX_D_VLD, bus.CMD_ERR, bus.BUSY} !== '0) begin
         errors++;
         $display("FAIL %s: got wr=%b rd=%b a=%h wd=%h tx=%h tv=%b err=%b busy=%b expected all 0",
                  name, bus.RF_WrEn, bus.RF_RdEn, bus.RF_Address, bus.RF_WrData,
                  bus.TX_P_DATA, bus.TX_D_VLD, bus.CMD_ERR, bus.BUSY);
      end
   endtask

   task automatic test_reset;
      RST = 1'b1;
      idle(3);
      check_outputs_zero("reset");
      RST = 1'b0;
      idle(1);
   endtask

   task automatic test_write_read;
      int n;
      shadow[7] = 8'h46;
      exp_wr.push_back({4'd7, 8'h46});
      send_byte(8'hAA);
      send_byte(8'h07);
      send_byte(8'h46);
      checks++;
      if (bus.RF_WrEn !== 1'b1) begin
         errors++;
         $display("FAIL wr_latency: got WrEn=%b expected 1", bus.RF_WrEn);
      end
      idle(2);
      tx_ready = 1'b0;
      exp_tx.push_back(shadow[7]);
      send_byte(8'hBB);
      send_byte(8'h07);
      checks++;
      if (bus.RF_RdEn !== 1'b1 || bus.TX_D_VLD !== 1'b0) begin
         errors++;
         $display("FAIL rd_latency: got RdEn=%b TxVld=%b expected 1 0", bus.RF_RdEn, bus.TX_D_VLD);
      end
      wait_tx_vld(20, n);
      repeat (5) begin
         checks++;
         if (bus.TX_D_VLD !== 1'b1 || bus.TX_P_DATA !== 8'h46) begin
            errors++;
            $display("FAIL tx_wait_ready: got vld=%b data=%h expected 1 46", bus.TX_D_VLD, bus.TX_P_DATA);
         end
         idle(1);
      end
      tx_ready = 1'b1;
      idle(1);
      checks++;
      if (bus.TX_D_VLD !== 1'b0) begin
         errors++;
         $display("FAIL tx_release: got vld=%b expected 0", bus.TX_D_VLD);
      end
      drain("write_read");
   endtask

   task automatic test_out_of_range;
      int e0;
      e0 = err_pulses;
      send_byte(8'hAA);
      send_byte(8'h10);
      idle(2);
      checks++;
      if (err_pulses !== e0 + 1 || bus.BUSY !== 1'b0) begin
         errors++;
         $display("FAIL wr_range: got pulses=%0d busy=%b expected %0d 0", err_pulses - e0, bus.BUSY, 1);
      end
      e0 = err_pulses;
      exp_tx.push_back(ERR_CODE);
      send_byte(8'hBB);
      send_byte(8'h12);
      idle(3);
      checks++;
      if (err_pulses !== e0 + 1) begin
         errors++;
         $display("FAIL rd_range: got pulses=%0d expected 1", err_pulses - e0);
      end
      drain("out_of_range");
   endtask

   task automatic test_gap_timeout;
      int e0;
      e0 = err_pulses;
      send_byte(8'hAA);
      send_byte(8'h05);
      idle(GAP_TIMEOUT - 2);
      checks++;
      if (bus.BUSY !== 1'b1 || err_pulses !== e0) begin
         errors++;
         $display("FAIL gap_early: got busy=%b pulses=%0d expected 1 0", bus.BUSY, err_pulses - e0);
      end
      idle(4);
      checks++;
      if (bus.BUSY !== 1'b0 || err_pulses !== e0 + 1) begin
         errors++;
         $display("FAIL gap_expire: got busy=%b pulses=%0d expected 0 1", bus.BUSY, err_pulses - e0);
      end
      shadow[5] = 8'h09;
      exp_wr.push_back({4'd5, 8'h09});
      send_byte(8'hAA);
      send_byte(8'h05);
      send_byte(8'h09);
      drain("gap_timeout");
   endtask

   task automatic test_read_timeout;
      int e0;
      int n;
      rf_stall = 1'b1;
      e0 = err_pulses;
      exp_tx.push_back(ERR_CODE);
      send_byte(8'hBB);
      send_byte(8'h03);
      wait_tx_vld(RD_TIMEOUT + 10, n);
      checks++;
      if (n < RD_TIMEOUT || n > RD_TIMEOUT + 2 || bus.TX_P_DATA !== ERR_CODE) begin
         errors++;
         $display("FAIL rd_timeout: got cycles=%0d data=%h expected %0d..%0d %h",
                  n, bus.TX_P_DATA, RD_TIMEOUT, RD_TIMEOUT + 2, ERR_CODE);
      end
      idle(1);
      checks++;
      if (err_pulses !== e0 + 1) begin
         errors++;
         $display("FAIL rd_timeout_err: got pulses=%0d expected 1", err_pulses - e0);
      end
      rf_stall = 1'b0;
      drain("read_timeout");
   endtask

   task automatic test_junk_overlap;
      int e0;
      int n;
      e0 = err_pulses;
      send_byte(8'h3C);
      idle(2);
      checks++;
      if (err_pulses !== e0 || bus.BUSY !== 1'b0) begin
         errors++;
         $display("FAIL junk: got pulses=%0d busy=%b expected 0 0", err_pulses - e0, bus.BUSY);
      end
      tx_ready = 1'b0;
      exp_tx.push_back(shadow[7]);
      send_byte(8'hBB);
      send_byte(8'h07);
      wait_tx_vld(20, n);
      e0 = err_pulses;
      send_byte(8'h55);
      idle(1);
      checks++;
      if (err_pulses !== e0 + 1 || bus.TX_D_VLD !== 1'b1 || bus.TX_P_DATA !== shadow[7]) begin
         errors++;
         $display("FAIL overlap: got pulses=%0d vld=%b data=%h expected 1 1 %h",
                  err_pulses - e0, bus.TX_D_VLD, bus.TX_P_DATA, shadow[7]);
      end
      tx_ready = 1'b1;
      idle(1);
      drain("junk_overlap");
   endtask

   task automatic test_reset_mid_frame;
      int e0;
      send_byte(8'hAA);
      send_byte(8'h04);
      RST = 1'b1;
      idle(1);
      check_outputs_zero("reset_mid_frame");
      RST = 1'b0;
      e0 = err_pulses;
      send_byte(8'h77);
      idle(3);
      checks++;
      if (bus.BUSY !== 1'b0 || err_pulses !== e0) begin
         errors++;
         $display("FAIL after_reset: got busy=%b pulses=%0d expected 0 0", bus.BUSY, err_pulses - e0);
      end
      drain("reset_mid_frame");
   endtask

   task automatic test_back_to_back;
      logic [3:0] addrs [6];
      logic [7:0] d;
      int n;
      for (int i = 0; i < 6; i++) begin
         addrs[i] = 4'($urandom_range(0, DEPTH - 1));
         d = 8'($urandom);
         shadow[addrs[i]] = d;
         exp_wr.push_back({addrs[i], d});
         send_byte(8'hAA);
         send_byte({4'h0, addrs[i]});
         send_byte(d);
         idle(1);
      end
      for (int i = 0; i < 6; i++) begin
         exp_tx.push_back(shadow[addrs[i]]);
         send_byte(8'hBB);
         send_byte({4'h0, addrs[i]});
         wait_tx_vld(20, n);
         idle(1);
      end
      drain("back_to_back");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write_read();
      test_out_of_range();
      test_gap_timeout();
      test_read_timeout();
      test_junk_overlap();
      test_reset_mid_frame();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
